// File: rtl/spi_wb_master_bridge.sv
// rtl/spi_wb_master_bridge.sv - SPI-slave (mode 0) to Wishbone-master bridge with bursts, timeout and status
module spi_wb_master_bridge #(
  parameter int ADDR_BYTES  = 4,
  parameter int DATA_BYTES  = 4,
  parameter int TIMEOUT     = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n_i,
  input  logic                    spi_sck,
  input  logic                    spi_mosi,
  input  logic                    spi_cs_n,
  output logic                    spi_miso,
  output logic                    wbs_cyc_o,
  output logic                    wbs_stb_o,
  output logic                    wbs_we_o,
  output logic [DATA_BYTES-1:0]   wbs_sel_o,
  output logic [8*ADDR_BYTES-1:0] wbs_adr_o,
  output logic [8*DATA_BYTES-1:0] wbs_dat_o,
  input  logic [8*DATA_BYTES-1:0] wbs_dat_i,
  input  logic                    wbs_ack_i
);
  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_RD_DUMMY, S_DATA, S_DONE} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, cs_sync_q;
  logic                   sck_prev_q;
  logic                   sck_s, mosi_s, cs_s, sck_rise, sck_fall;

  logic [2:0] bit_cnt_q;
  logic [6:0] rx_sh_q;
  logic [7:0] tx_sh_q, tx_next_q, rx_byte, status_byte;
  logic       miso_q, byte_done;

  state_t          state_q;
  logic            burst_q, rd_q, rd_valid_q, cyc_rd_q, ovr_word_q, launch_q;
  logic            cyc_q, we_q, tmo_flag_q, ovr_flag_q;
  logic [7:0]      cnt_q;
  logic [15:0]     tmo_q;
  logic [AW-1:0]   addr_q, adr_o_q;
  logic [DW-1:0]   wr_word_q, wr_word_d, word_sh_q, rd_word_q, dat_o_q;

  assign sck_s       = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign sck_rise    = sck_s & ~sck_prev_q;
  assign sck_fall    = ~sck_s & sck_prev_q;
  assign rx_byte     = {rx_sh_q, mosi_s};
  assign byte_done   = sck_rise & ~cs_s & (bit_cnt_q == 3'd7);
  assign status_byte = {5'b0, ovr_flag_q, tmo_flag_q, cyc_q};

  assign spi_miso  = miso_q;
  assign wbs_cyc_o = cyc_q;
  assign wbs_stb_o = cyc_q;
  assign wbs_we_o  = we_q;
  assign wbs_sel_o = {DATA_BYTES{cyc_q}};
  assign wbs_adr_o = adr_o_q;
  assign wbs_dat_o = dat_o_q;

  always_comb begin
    wr_word_d = wr_word_q;
    for (int i = 0; i < DATA_BYTES; i++)
      if (cnt_q == 8'(i)) wr_word_d[8*i +: 8] = rx_byte;
  end

  // Pin synchronisers plus the bit-level shifters; MISO moves on sck falling edges only.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sck_prev_q  <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_sh_q     <= 7'd0;
      tx_sh_q     <= 8'd0;
      miso_q      <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      sck_prev_q  <= sck_s;
      if (cs_s) begin
        bit_cnt_q <= 3'd0;
        tx_sh_q   <= 8'd0;
        miso_q    <= 1'b0;
      end else begin
        if (sck_rise) begin
          rx_sh_q   <= rx_byte[6:0];
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
        if (sck_fall) begin
          if (bit_cnt_q == 3'd0) begin
            miso_q  <= tx_next_q[7];
            tx_sh_q <= {tx_next_q[6:0], 1'b0};
          end else begin
            miso_q  <= tx_sh_q[7];
            tx_sh_q <= {tx_sh_q[6:0], 1'b0};
          end
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= S_IDLE;
      burst_q    <= 1'b0;
      rd_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      cyc_rd_q   <= 1'b0;
      ovr_word_q <= 1'b0;
      launch_q   <= 1'b0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      tmo_flag_q <= 1'b0;
      ovr_flag_q <= 1'b0;
      cnt_q      <= 8'd0;
      tmo_q      <= 16'd0;
      addr_q     <= '0;
      adr_o_q    <= '0;
      wr_word_q  <= '0;
      word_sh_q  <= '0;
      rd_word_q  <= '0;
      dat_o_q    <= '0;
      tx_next_q  <= 8'd0;
    end else begin
      // Bus side runs independently of the frame so a cycle survives a cs_n rise.
      if (cyc_q) begin
        if (wbs_ack_i) begin
          cyc_q <= 1'b0;
          we_q  <= 1'b0;
          if (cyc_rd_q) begin
            rd_word_q  <= wbs_dat_i;
            rd_valid_q <= 1'b1;
            cyc_rd_q   <= 1'b0;
          end
        end else if (tmo_q == 16'(TIMEOUT - 1)) begin
          cyc_q      <= 1'b0;
          we_q       <= 1'b0;
          tmo_flag_q <= 1'b1;
          if (cyc_rd_q) begin
            rd_word_q  <= '1;
            rd_valid_q <= 1'b1;
            cyc_rd_q   <= 1'b0;
          end
        end else begin
          tmo_q <= tmo_q + 16'd1;
        end
      end else if (launch_q && !cs_s) begin
        launch_q <= 1'b0;
        cyc_q    <= 1'b1;
        we_q     <= 1'b0;
        adr_o_q  <= addr_q;
        tmo_q    <= 16'd0;
        cyc_rd_q <= 1'b1;
      end

      if (cs_s) begin
        state_q    <= S_IDLE;
        launch_q   <= 1'b0;
        cyc_rd_q   <= 1'b0;
        rd_valid_q <= 1'b0;
      end else if (state_q == S_IDLE) begin
        state_q <= S_CMD;
      end else if (byte_done) begin
        tx_next_q <= 8'h00;
        case (state_q)
          S_CMD: begin
            cnt_q   <= 8'd0;
            burst_q <= rx_byte[4];
            rd_q    <= rx_byte[1];
            case (rx_byte)
              8'h01, 8'h02, 8'h11, 8'h12: state_q <= S_ADDR;
              8'h05: begin
                tx_next_q  <= status_byte;
                tmo_flag_q <= 1'b0;
                ovr_flag_q <= 1'b0;
                state_q    <= S_DONE;
              end
              default: state_q <= S_DONE;
            endcase
          end
          S_ADDR: begin
            for (int i = 0; i < ADDR_BYTES; i++)
              if (cnt_q == 8'(i)) addr_q[8*i +: 8] <= rx_byte;
            if (cnt_q == 8'(ADDR_BYTES - 1)) begin
              cnt_q <= 8'd0;
              if (rd_q) begin
                launch_q <= 1'b1;
                state_q  <= S_RD_DUMMY;
              end else begin
                state_q <= S_DATA;
              end
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          S_RD_DUMMY, S_DATA: begin
            if (rd_q) begin
              if (state_q == S_RD_DUMMY || cnt_q == 8'(DATA_BYTES)) begin
                if (state_q == S_DATA && !burst_q) begin
                  state_q <= S_DONE;
                end else begin
                  // Word boundary: load the captured word, or flag overrun and send 0xFF.
                  state_q <= S_DATA;
                  cnt_q   <= 8'd1;
                  if (rd_valid_q) begin
                    tx_next_q  <= rd_word_q[7:0];
                    word_sh_q  <= rd_word_q >> 8;
                    ovr_word_q <= 1'b0;
                  end else begin
                    tx_next_q  <= 8'hFF;
                    ovr_word_q <= 1'b1;
                    ovr_flag_q <= 1'b1;
                    cyc_rd_q   <= 1'b0;
                  end
                  rd_valid_q <= 1'b0;
                  if (burst_q) begin
                    launch_q <= 1'b1;
                    addr_q   <= addr_q + AW'(DATA_BYTES);
                  end
                end
              end else begin
                tx_next_q <= ovr_word_q ? 8'hFF : word_sh_q[7:0];
                word_sh_q <= word_sh_q >> 8;
                cnt_q     <= cnt_q + 8'd1;
              end
            end else begin
              wr_word_q <= wr_word_d;
              if (cnt_q == 8'(DATA_BYTES - 1)) begin
                cnt_q <= 8'd0;
                if (cyc_q) begin
                  ovr_flag_q <= 1'b1;
                end else begin
                  cyc_q    <= 1'b1;
                  we_q     <= 1'b1;
                  adr_o_q  <= addr_q;
                  dat_o_q  <= wr_word_d;
                  tmo_q    <= 16'd0;
                  cyc_rd_q <= 1'b0;
                end
                if (burst_q) addr_q <= addr_q + AW'(DATA_BYTES);
                else         state_q <= S_DONE;
              end else begin
                cnt_q <= cnt_q + 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_wb_master_bridge.sv
// tb/tb_spi_wb_master_bridge.sv - directed self-checking bench for spi_wb_master_bridge
module tb_spi_wb_master_bridge;
  localparam int HALF = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sck, mosi, cs_a, cs_b;
  logic        miso_a, cyc_a, stb_a, we_a, ack_a;
  logic        miso_b, cyc_b, stb_b, we_b, ack_b;
  logic [3:0]  sel_a, sel_b;
  logic [31:0] adr_a, dato_a, dati_a, adr_b, dato_b, dati_b;

  spi_wb_master_bridge #(.ADDR_BYTES(4), .DATA_BYTES(4), .TIMEOUT(16), .SYNC_STAGES(2)) u_a (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .spi_sck(sck), .spi_mosi(mosi), .spi_cs_n(cs_a),
    .spi_miso(miso_a), .wbs_cyc_o(cyc_a), .wbs_stb_o(stb_a), .wbs_we_o(we_a), .wbs_sel_o(sel_a),
    .wbs_adr_o(adr_a), .wbs_dat_o(dato_a), .wbs_dat_i(dati_a), .wbs_ack_i(ack_a));

  spi_wb_master_bridge #(.ADDR_BYTES(4), .DATA_BYTES(4), .TIMEOUT(4000), .SYNC_STAGES(2)) u_b (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .spi_sck(sck), .spi_mosi(mosi), .spi_cs_n(cs_b),
    .spi_miso(miso_b), .wbs_cyc_o(cyc_b), .wbs_stb_o(stb_b), .wbs_we_o(we_b), .wbs_sel_o(sel_b),
    .wbs_adr_o(adr_b), .wbs_dat_o(dato_b), .wbs_dat_i(dati_b), .wbs_ack_i(ack_b));

  // Slave A: ack after a programmable delay, can be muted; logs every acked cycle.
  int          ack_dly_a = 3;
  bit          ack_en_a = 1'b1;
  int          wait_a = 0;
  int          run_a = 0, last_run_a = 0;
  logic [31:0] log_adr[$], log_dat[$];
  logic        log_we[$];
  logic [3:0]  log_sel[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      ack_a  <= 1'b0;
      wait_a <= 0;
    end else if (cyc_a && !ack_a && ack_en_a) begin
      if (wait_a >= ack_dly_a - 1) begin
        ack_a  <= 1'b1;
        wait_a <= 0;
      end else begin
        wait_a <= wait_a + 1;
      end
    end else begin
      ack_a  <= 1'b0;
      wait_a <= 0;
    end
    if (rst_n && cyc_a && ack_a) begin
      log_adr.push_back(adr_a);
      log_dat.push_back(dato_a);
      log_we.push_back(we_a);
      log_sel.push_back(sel_a);
    end
    if (cyc_a) run_a = run_a + 1;
    else if (run_a != 0) begin
      last_run_a = run_a;
      run_a = 0;
    end
  end

  // Slave B: acks only while fewer than ack_limit_b cycles have been acked.
  int          ack_limit_b = 1;
  int          acks_b = 0;
  logic [31:0] last_adr_b = '0;

  always @(posedge clk) begin
    if (!rst_n) ack_b <= 1'b0;
    else if (cyc_b && !ack_b && acks_b < ack_limit_b) ack_b <= 1'b1;
    else ack_b <= 1'b0;
    if (rst_n && cyc_b && ack_b) begin
      acks_b = acks_b + 1;
      last_adr_b = adr_b;
    end
  end

  int          n_assert = 0, n_fail = 0;
  int          dev = 0;
  logic [7:0]  tx_buf[0:15];
  logic [7:0]  rx_buf[0:15];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_byte(input logic [7:0] t, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) begin
      mosi = t[i];
      tick(HALF);
      r[i] = (dev == 0) ? miso_a : miso_b;
      sck = 1'b1;
      tick(HALF);
      sck = 1'b0;
    end
  endtask

  // v holds n bytes right-aligned; the first byte sent is the most significant of those n.
  task automatic frame(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) tx_buf[i] = v[8*(n-1-i) +: 8];
    if (dev == 0) cs_a = 1'b0;
    else          cs_b = 1'b0;
    tick(HALF);
    for (int i = 0; i < n; i++) begin
      logic [7:0] r;
      spi_byte(tx_buf[i], r);
      rx_buf[i] = r;
    end
    tick(HALF);
    cs_a = 1'b1;
    cs_b = 1'b1;
    tick(4 * HALF);
  endtask

  initial begin
    rst_n  = 1'b0;
    sck    = 1'b0;
    mosi   = 1'b0;
    cs_a   = 1'b1;
    cs_b   = 1'b1;
    dati_a = 32'h0;
    dati_b = 32'h89ABCDEF;
    tick(5);
    check("rst_ctl", {cyc_a, stb_a, we_a, sel_a, miso_a}, 64'h0);
    check("rst_adr", adr_a, 64'h0);
    check("rst_dat", dato_a, 64'h0);
    rst_n = 1'b1;
    tick(5);

    // 1: single write
    frame({8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12}, 9);
    tick(20);
    check("wr_count", log_adr.size(), 64'd1);
    check("wr_adr", log_adr[0], 64'h10);
    check("wr_dat", log_dat[0], 64'h12345678);
    check("wr_we", log_we[0], 64'h1);
    check("wr_sel", log_sel[0], 64'hF);

    // 2: single read
    dati_a = 32'hCAFEBABE;
    frame({8'h02, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 10);
    tick(20);
    check("rd_dummy", rx_buf[5], 64'h00);
    check("rd_byte0", rx_buf[6], 64'hBE);
    check("rd_byte1", rx_buf[7], 64'hBA);
    check("rd_byte2", rx_buf[8], 64'hFE);
    check("rd_byte3", rx_buf[9], 64'hCA);
    check("rd_count", log_adr.size(), 64'd2);
    check("rd_adr", log_adr[1], 64'h20);
    check("rd_we", log_we[1], 64'h0);

    // 3: burst write wrapping the address
    frame({8'h11, 8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'h44, 8'h33, 8'h22, 8'h11,
           8'h5A, 8'h5A, 8'hA5, 8'hA5}, 13);
    tick(20);
    check("bw_count", log_adr.size(), 64'd4);
    check("bw_adr0", log_adr[2], 64'hFFFFFFFC);
    check("bw_dat0", log_dat[2], 64'h11223344);
    check("bw_adr1", log_adr[3], 64'h00000000);
    check("bw_dat1", log_dat[3], 64'hA5A55A5A);

    // 4: read with no ack -> timeout, then sticky status read and clear
    ack_en_a = 1'b0;
    frame({8'h02, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 10);
    check("to_cyc_len", last_run_a, 64'd16);
    check("to_rd_word", {rx_buf[9], rx_buf[8], rx_buf[7], rx_buf[6]}, 64'hFFFFFFFF);
    check("to_no_ack", log_adr.size(), 64'd4);
    frame({8'h05, 8'h00}, 2);
    check("to_status", rx_buf[1], 64'h02);
    frame({8'h05, 8'h00}, 2);
    check("to_status_clr", rx_buf[1], 64'h00);
    ack_en_a = 1'b1;

    // 5: burst read on instance B with the 2nd read's ack withheld
    dev = 1;
    frame({8'h12, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
           8'h00, 8'h00, 8'h00, 8'h00}, 14);
    check("br_word0", {rx_buf[9], rx_buf[8], rx_buf[7], rx_buf[6]}, 64'h89ABCDEF);
    check("br_word1", {rx_buf[13], rx_buf[12], rx_buf[11], rx_buf[10]}, 64'hFFFFFFFF);
    ack_limit_b = 2;
    tick(20);
    check("br_acks", acks_b, 64'd2);
    check("br_adr1", last_adr_b, 64'h104);
    frame({8'h05, 8'h00}, 2);
    check("br_status", rx_buf[1], 64'h04);
    frame({8'h05, 8'h00}, 2);
    check("br_status_clr", rx_buf[1], 64'h00);

    // 6: aborted write then a clean single write
    dev = 0;
    frame({8'h01, 8'h30, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB}, 7);
    tick(50);
    check("ab_no_cycle", log_adr.size(), 64'd4);
    frame({8'h01, 8'h34, 8'h00, 8'h00, 8'h00, 8'hDD, 8'hCC, 8'hBB, 8'hAA}, 9);
    tick(20);
    check("ab_count", log_adr.size(), 64'd5);
    check("ab_adr", log_adr[4], 64'h34);
    check("ab_dat", log_dat[4], 64'hAABBCCDD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
